// File: rtl/video2ram.sv
// Dreamcast two-phase 12-bit video capture: rebuilds 24-bit pixels, tracks raster position from
// the sync edges and writes active pixels into the line-buffer RAM, flagging when it is primed.
module video2ram #(
    parameter int unsigned RAM_ADDRESS_BITS = 14,
    parameter int unsigned H_ACTIVE         = 640,
    parameter int unsigned V_ACTIVE         = 480,
    parameter int unsigned H_START          = 118,
    parameter int unsigned V_START          = 36,
    parameter int unsigned BUFFER_LINES     = 16,
    parameter int unsigned TRIGGER_LINE     = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [11:0]                 data,
    input  logic                        _hsync,
    input  logic                        _vsync,
    input  logic                        line_doubler,
    output logic [RAM_ADDRESS_BITS-1:0] wraddr,
    output logic [23:0]                 wrdata,
    output logic                        wren,
    output logic                        starttrigger
);

    typedef enum logic {StWaitVsync, StCapture} state_e;

    state_e                      state_q, state_d;
    logic [11:0]                 data_q, hold_q, hold_d;
    logic                        hsync_q, hsync_prev_q, vsync_q, vsync_prev_q;
    logic                        ld_q, ld_prev_q;
    logic                        phase_q, phase_d;
    logic [10:0]                 pixcnt_q, pixcnt_d;
    logic [9:0]                  linecnt_q, linecnt_d;
    logic [RAM_ADDRESS_BITS-1:0] wraddr_q, wraddr_d;
    logic [23:0]                 wrdata_q, wrdata_d;
    logic                        wren_q, wren_d;
    logic                        trig_q, trig_d;

    logic                        hf, vf, ld_chg, in_x, in_y, pixel_done, last_px;
    logic [31:0]                 pix_x, pix_y, row, v_lim;
    logic [RAM_ADDRESS_BITS-1:0] addr_norm, addr_dbl;

    assign hf     = hsync_prev_q & ~hsync_q;
    assign vf     = vsync_prev_q & ~vsync_q;
    assign ld_chg = ld_q ^ ld_prev_q;

    // Below-start positions wrap to huge unsigned values, so one compare bounds each axis.
    assign pix_x     = 32'(pixcnt_q) - H_START;
    assign pix_y     = 32'(linecnt_q) - V_START;
    assign v_lim     = ld_q ? V_ACTIVE / 2 : V_ACTIVE;
    assign in_x      = pix_x < H_ACTIVE;
    assign in_y      = pix_y < v_lim;
    assign row       = pix_y & (BUFFER_LINES - 1);
    assign addr_norm = RAM_ADDRESS_BITS'(row * H_ACTIVE + pix_x);
    assign addr_dbl  = RAM_ADDRESS_BITS'({pix_y[1:0], pix_x[9:0]});
    assign last_px   = (pix_x == H_ACTIVE - 1) && (pix_y == TRIGGER_LINE);

    // A sync edge or mode change on the completing cycle drops the half-built pixel.
    assign pixel_done = (state_q == StCapture) && phase_q && !hf && !vf && !ld_chg && in_x && in_y;

    always_comb begin
        state_d = state_q;
        if (ld_chg) begin
            state_d = StWaitVsync;
        end else if (state_q == StWaitVsync && vf) begin
            state_d = StCapture;
        end

        phase_d  = hf ? 1'b0 : ~phase_q;
        pixcnt_d = pixcnt_q;
        if (hf) begin
            pixcnt_d = '0;
        end else if (phase_q && pixcnt_q != 11'h7ff) begin
            pixcnt_d = pixcnt_q + 11'd1;
        end

        linecnt_d = linecnt_q;
        if (vf) begin
            linecnt_d = '0;
        end else if (hf && linecnt_q != 10'h3ff) begin
            linecnt_d = linecnt_q + 10'd1;
        end

        hold_d   = phase_q ? hold_q : data_q;
        wren_d   = pixel_done;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        if (pixel_done) begin
            wraddr_d = ld_q ? addr_dbl : addr_norm;
            wrdata_d = {hold_q, data_q};
        end

        trig_d = trig_q;
        if (ld_chg || state_q == StWaitVsync) begin
            trig_d = 1'b0;
        end else if (pixel_done && last_px) begin
            trig_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StWaitVsync;
            data_q       <= '0;
            hold_q       <= '0;
            hsync_q      <= 1'b1;
            hsync_prev_q <= 1'b1;
            vsync_q      <= 1'b1;
            vsync_prev_q <= 1'b1;
            ld_q         <= 1'b0;
            ld_prev_q    <= 1'b0;
            phase_q      <= 1'b0;
            pixcnt_q     <= '0;
            linecnt_q    <= '0;
            wraddr_q     <= '0;
            wrdata_q     <= '0;
            wren_q       <= 1'b0;
            trig_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data;
            hold_q       <= hold_d;
            hsync_q      <= _hsync;
            hsync_prev_q <= hsync_q;
            vsync_q      <= _vsync;
            vsync_prev_q <= vsync_q;
            ld_q         <= line_doubler;
            ld_prev_q    <= ld_q;
            phase_q      <= phase_d;
            pixcnt_q     <= pixcnt_d;
            linecnt_q    <= linecnt_d;
            wraddr_q     <= wraddr_d;
            wrdata_q     <= wrdata_d;
            wren_q       <= wren_d;
            trig_q       <= trig_d;
        end
    end

    assign wraddr       = wraddr_q;
    assign wrdata       = wrdata_q;
    assign wren         = wren_q;
    assign starttrigger = trig_q;

endmodule

// File: tb/tb_video2ram.sv
// Bench for video2ram on a shrunken raster: a source model drives whole frames, a scoreboard
// checks every write, and a table of hand-computed spot values checks addresses and data.
module tb_video2ram;

    localparam int AB = 12, HA = 16, HS = 6, VA = 20, VS = 3, BL = 16, TL = 2;
    localparam int LINE_CYC = 56, FRAME_LINES = 26, HSYNC_LEN = 4;

    logic          clock = 1'b0;
    logic          reset, hs, vs, ld;
    logic [11:0]   data;
    logic [AB-1:0] wraddr;
    logic [23:0]   wrdata;
    logic          wren, starttrigger;

    video2ram #(
        .RAM_ADDRESS_BITS(AB), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HS), .V_START(VS),
        .BUFFER_LINES(BL), .TRIGGER_LINE(TL)
    ) dut (
        .clock(clock), .reset(reset), .data(data), ._hsync(hs), ._vsync(vs),
        .line_doubler(ld), .wraddr(wraddr), .wrdata(wrdata), .wren(wren),
        .starttrigger(starttrigger)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {int x; int y; bit ld; logic [AB-1:0] addr; logic [23:0] dat; int due;} wr_t;
    typedef struct {bit ld; int x; int y; logic [AB-1:0] addr; logic [23:0] dat;} vec_t;

    wr_t           expq[$];
    wr_t           e;
    vec_t          vecs[8];
    logic [AB-1:0] rec_addr[2][VA][HA];
    logic [23:0]   rec_data[2][VA][HA];

    int errors = 0, checks = 0;
    bit armed = 1'b0, trig_exp = 1'b0;
    int trig_dc_end = 0, drop_chk_at = -1;
    int wr_cnt = 0, wr_y1 = 0;
    int rst_ln = -1, rst_k = -1, tog_ln = -1, tog_k = -1, trunc_ln = -1, trunc_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] pix(input int px, input int ln, input bit l);
        if (!l && px == HS + 7 && ln == VS + 4) return 24'hAB53CD;
        return {4'hC, 10'(ln), 10'(px)};
    endfunction

    function automatic logic [AB-1:0] exp_addr(input int x, input int y, input bit l);
        if (l) return AB'({y[1:0], x[9:0]});
        return AB'((y % BL) * HA + x);
    endfunction

    // Scoreboard: every wren must match the oldest outstanding pixel on its due cycle.
    always @(negedge clock) begin
        while (expq.size() > 0 && expq[0].due < cyc) begin
            check("write_missing_due", 32'(cyc), 32'(expq[0].due));
            void'(expq.pop_front());
        end
        if (wren) begin
            if (expq.size() == 0) begin
                check("unexpected_wren", 32'(wren), 32'd0);
            end else begin
                e = expq.pop_front();
                check("write_cycle", 32'(cyc), 32'(e.due));
                check("wraddr", 32'(wraddr), 32'(e.addr));
                check("wrdata", 32'(wrdata), 32'(e.dat));
                rec_addr[e.ld][e.y][e.x] = wraddr;
                rec_data[e.ld][e.y][e.x] = wrdata;
                wr_cnt++;
                if (e.y == 1 && !e.ld) wr_y1++;
                if (e.x == HA - 1 && e.y == TL) trig_exp = 1'b1;
            end
        end
        if (cyc >= trig_dc_end) check("starttrigger", 32'(starttrigger), 32'(trig_exp));
        if (cyc == drop_chk_at) begin
            check("drop_wren", 32'(wren), 32'd0);
            check("drop_starttrigger", 32'(starttrigger), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int ln, input int k);
        logic [23:0] w;
        int p, x, y, vlim;
        tick();
        if (ln == rst_ln && k == rst_k) begin
            reset       = 1'b0;
            armed       = 1'b0;
            trig_exp    = 1'b0;
            trig_dc_end = cyc + 1;
            drop_chk_at = cyc + 1;
            while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
        end
        if (ln == rst_ln && k == rst_k + 3) reset = 1'b1;
        if (ln == tog_ln && k == tog_k) begin
            ld          = ~ld;
            armed       = 1'b0;
            trig_exp    = 1'b0;
            trig_dc_end = cyc + 2;
            drop_chk_at = cyc + 2;
        end
        hs = (k < HSYNC_LEN) ? 1'b0 : 1'b1;
        vs = (ln < 2) ? 1'b0 : 1'b1;
        if (ln == 0 && k == 0 && reset) armed = 1'b1;
        if (k == 0) begin
            data = 12'h000;
        end else begin
            p = (k - 1) / 2;
            w = pix(p, ln, ld);
            if ((k - 1) % 2 == 0) begin
                data = w[23:12];
            end else begin
                data = w[11:0];
                x    = p - HS;
                y    = ln - VS;
                vlim = ld ? VA / 2 : VA;
                if (armed && reset && x >= 0 && x < HA && y >= 0 && y < vlim)
                    expq.push_back('{x, y, ld, exp_addr(x, y, ld), w, cyc + 2});
            end
        end
    endtask

    task automatic run_lines(input int first, input int last);
        int len;
        for (int ln = first; ln <= last; ln++) begin
            len = (ln == trunc_ln) ? trunc_len : LINE_CYC;
            for (int k = 0; k < len; k++) drive(ln, k);
        end
    endtask

    task automatic run_frame(input int exp_writes, input string name);
        wr_cnt = 0;
        run_lines(0, FRAME_LINES - 1);
        check(name, 32'(wr_cnt), 32'(exp_writes));
    endtask

    initial begin
        vecs[0] = '{1'b0, 0, 0, 12'h000, 24'hC00C06};
        vecs[1] = '{1'b0, 5, 17, 12'h015, 24'hC0500B};
        vecs[2] = '{1'b0, 15, 15, 12'h0FF, 24'hC04815};
        vecs[3] = '{1'b0, 3, 16, 12'h003, 24'hC04C09};
        vecs[4] = '{1'b0, 7, 4, 12'h047, 24'hAB53CD};
        vecs[5] = '{1'b1, 10, 5, 12'h40A, 24'hC02010};
        vecs[6] = '{1'b1, 0, 9, 12'h400, 24'hC03006};
        vecs[7] = '{1'b1, 15, 3, 12'hC0F, 24'hC01815};

        reset = 1'b0;
        hs    = 1'b1;
        vs    = 1'b1;
        ld    = 1'b0;
        data  = 12'h000;
        repeat (3) tick();
        @(negedge clock);
        check("reset_wraddr", 32'(wraddr), 32'd0);
        check("reset_wrdata", 32'(wrdata), 32'd0);
        check("reset_wren", 32'(wren), 32'd0);
        check("reset_starttrigger", 32'(starttrigger), 32'd0);
        tick();
        reset = 1'b1;

        // Sync-up mid-frame: nothing may be written before the first vsync fall.
        wr_cnt = 0;
        run_lines(12, FRAME_LINES - 1);
        check("partial_frame_writes", 32'(wr_cnt), 32'd0);

        run_frame(320, "frame1_writes");
        run_frame(320, "frame2_writes");

        // Switch to doubler after line 10 (y=7): the rest of the frame is discarded.
        tog_ln = 10;
        tog_k  = 50;
        run_frame(128, "ld_on_frame_writes");
        tog_ln = -1;
        run_frame(160, "doubler_frame_writes");

        for (int i = 0; i < 8; i++) begin
            check($sformatf("vec%0d_addr", i),
                  32'(rec_addr[vecs[i].ld][vecs[i].y][vecs[i].x]), 32'(vecs[i].addr));
            check($sformatf("vec%0d_data", i),
                  32'(rec_data[vecs[i].ld][vecs[i].y][vecs[i].x]), 32'(vecs[i].dat));
        end

        tog_ln = 8;
        tog_k  = 50;
        run_frame(96, "ld_off_frame_writes");
        tog_ln = -1;

        // Reset at x=8 of y=5: x=0..6 land, x=7 is in flight and dropped.
        rst_ln = VS + 5;
        rst_k  = 2 * (HS + 8) + 1;
        run_frame(87, "reset_frame_writes");
        rst_ln = -1;

        // y=1 cut short after the phase-0 word of x=5: only x=0..4 are written.
        trunc_ln  = VS + 1;
        trunc_len = 2 * (HS + 5) + 2;
        wr_y1     = 0;
        run_frame(309, "trunc_frame_writes");
        check("trunc_line_writes", 32'(wr_y1), 32'd5);
        trunc_ln = -1;

        repeat (8) tick();
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
